bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Multi-master bus arbiter. Sits directly upstream of the bus client/slave, between NUM_MASTERS requesters and one shared slave port.
- Grants one master at a time using round-robin priority and latches that master's address, direction and write data.
- Runs a single rq/ack transaction on the slave port, then returns the slave's read data and a one-cycle ack to the granted master.
- A timeout counter aborts transactions the slave never acknowledges.

Parameters:
DATA_WIDTH, 8, data bus width
ADDR_WIDTH, 4, address bus width
NUM_MASTERS, 4, number of requesting masters (2..8)
TIMEOUT, 16, max cycles waiting for s_ack before abort (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
m_rq  input  NUM_MASTERS  per-master request, held until that master's m_ack
m_address  input  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_wr_ni  input  NUM_MASTERS  per-master direction, 1 = read, 0 = write
m_dataW  input  NUM_MASTERS*DATA_WIDTH  packed write data
m_grant  output  NUM_MASTERS  one-hot, marks the master owning the current transaction
m_ack  output  NUM_MASTERS  one-hot, one-cycle completion pulse
m_err  output  1  high together with m_ack when the transaction timed out
m_dataR  output  DATA_WIDTH  read data returned to the acked master
s_address  output  ADDR_WIDTH  slave address
s_rq  output  1  slave request
s_wr_ni  output  1  slave direction, 1 = read, 0 = write
s_dataW  output  DATA_WIDTH  slave write data
s_ack  input  1  slave acknowledge, one-cycle pulse
s_dataR  input  DATA_WIDTH  slave read data, valid while s_ack = 1

Behaviour:
- Reset (reset = 0, asynchronous):
  - All outputs are 0.
  - State = IDLE, priority pointer = 0, timeout counter = 0.
  - Reset asserted mid-transaction aborts it immediately. No m_ack is issued.
- All outputs are registered.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If m_rq != 0, pick the winner: the first set bit scanning pointer, pointer+1, … with wrap modulo NUM_MASTERS.
  - At that edge: latch the winner's address, wr_ni and dataW onto s_address/s_wr_ni/s_dataW; set m_grant[winner] = 1, s_rq = 1, counter = 0; go to REQ.
  - Otherwise stay in IDLE with s_rq = 0.
- REQ:
  - s_rq stays high and all s_* outputs stay stable.
  - Counter increments each cycle.
  - If s_ack = 1 is sampled: m_dataR <= s_dataR, but only when latched wr_ni = 1; on a write, m_dataR holds its previous value. Also m_ack[winner] <= 1, m_err <= 0, s_rq <= 0; go to RESP.
  - Else, if the counter reaches TIMEOUT-1: m_ack[winner] <= 1, m_err <= 1, s_rq <= 0, m_dataR unchanged; go to RESP.
  - s_ack takes precedence over timeout on the same cycle.
- RESP:
  - m_ack/m_err are high for exactly this cycle.
  - Pointer <= winner+1 (mod NUM_MASTERS).
  - At exit: m_grant, m_ack, m_err <= 0; go to IDLE.
- s_rq is low for at least 2 cycles (RESP + IDLE) between transactions, so every transaction produces a fresh rising edge on s_rq.
- s_ack sampled outside REQ is ignored.
- A master dropping m_rq while in REQ does not cancel the transaction; completion and m_ack are still issued.
- A master keeping m_rq high after its m_ack is treated as a new request. Because the pointer has advanced, any other pending master wins first.
- Latency: master's m_rq sampled in IDLE at edge N → s_rq high after N → s_ack sampled at edge K → m_ack high for cycle K+1.
  - With a slave acking one cycle after seeing rq, m_ack rises 3 cycles after the sampling edge.
- Fairness: with all masters continuously requesting, grants rotate 0,1,2,3,0,…

Test Plan:
- Single read: reset = 0 for 3 cycles, then 1. Master 2 requests with address 4'hA, wr_ni = 1; slave acks after 1 cycle with dataR = 8'h5C → s_address = 4'hA, s_wr_ni = 1, then m_ack = 4'b0100 for one cycle with m_dataR = 8'h5C, m_err = 0.
- Write: master 0 requests with wr_ni = 0, dataW = 8'h3E → s_dataW = 8'h3E, s_wr_ni = 0 during REQ; m_ack = 4'b0001; m_dataR unchanged.
- Round robin: all four masters hold m_rq high → grant order 0,1,2,3,0. Every transaction shows a fresh s_rq rising edge with ≥ 2 low cycles between transactions.
- Timeout: slave never acks, TIMEOUT = 16, master 1 requests → s_rq high for 16 cycles, then m_ack = 4'b0010 with m_err = 1. The next request proceeds normally.
- Reset mid-op: reset = 0 while in REQ → s_rq, m_grant and m_ack drop to 0 immediately (asynchronously). After release, pointer = 0 and master 0 wins when masters 0 and 3 both request.
- Late ack: drive s_ack = 1 while in IDLE → ignored, no m_ack; drive s_ack and the timeout expiry on the same cycle → m_err = 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter: one master at a time drives a single rq/ack slave port; all outputs registered.
// Grant to slave rq is 1 edge; m_ack pulses the cycle after s_ack or after TIMEOUT cycles (m_err); masters hold m_rq until acked.
module bus_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_rq,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]            m_wr_ni,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dataW,
    output logic [NUM_MASTERS-1:0]            m_grant,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic                              m_err,
    output logic [DATA_WIDTH-1:0]             m_dataR,
    output logic [ADDR_WIDTH-1:0]             s_address,
    output logic                              s_rq,
    output logic                              s_wr_ni,
    output logic [DATA_WIDTH-1:0]             s_dataW,
    input  logic                              s_ack,
    input  logic [DATA_WIDTH-1:0]             s_dataR
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           win_q, win_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic [NUM_MASTERS-1:0]  ack_q, ack_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   data_r_q, data_r_d;
    logic [ADDR_WIDTH-1:0]   s_addr_q, s_addr_d;
    logic                    s_rq_q, s_rq_d;
    logic                    s_wr_q, s_wr_d;
    logic [DATA_WIDTH-1:0]   s_data_w_q, s_data_w_d;

    logic [NUM_MASTERS-1:0]  rot;
    logic                    win_vld;
    logic [PW-1:0]           win_idx;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    sel_wr;
    logic [DATA_WIDTH-1:0]   sel_data;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int unsigned b);
        logic [PW:0] s;
        s = {1'b0, a} + (PW+1)'(b);
        if (s >= (PW+1)'(NUM_MASTERS)) s = s - (PW+1)'(NUM_MASTERS);
        return s[PW-1:0];
    endfunction

    // Rotate requests so bit 0 is the highest-priority master; scanning downward leaves the first hit.
    always_comb begin
        rot      = NUM_MASTERS'({m_rq, m_rq} >> ptr_q);
        win_vld  = |m_rq;
        win_idx  = '0;
        sel_addr = '0;
        sel_wr   = 1'b0;
        sel_data = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (rot[i]) win_idx = wrap_add(ptr_q, unsigned'(i));
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_idx == PW'(i)) begin
                sel_addr = m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wr   = m_wr_ni[i];
                sel_data = m_dataW[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        ack_d      = ack_q;
        err_d      = err_q;
        data_r_d   = data_r_q;
        s_addr_d   = s_addr_q;
        s_rq_d     = s_rq_q;
        s_wr_d     = s_wr_q;
        s_data_w_d = s_data_w_q;
        case (state_q)
            IDLE: begin
                s_rq_d = 1'b0;
                if (win_vld) begin
                    state_d    = REQ;
                    win_d      = win_idx;
                    grant_d    = NUM_MASTERS'(1) << win_idx;
                    s_addr_d   = sel_addr;
                    s_wr_d     = sel_wr;
                    s_data_w_d = sel_data;
                    s_rq_d     = 1'b1;
                    cnt_d      = '0;
                end
            end
            REQ: begin
                if (s_ack) begin
                    state_d = RESP;
                    ack_d   = grant_q;
                    err_d   = 1'b0;
                    s_rq_d  = 1'b0;
                    if (s_wr_q) data_r_d = s_dataR;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    ack_d   = grant_q;
                    err_d   = 1'b1;
                    s_rq_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = wrap_add(win_q, 1);
                grant_d = '0;
                ack_d   = '0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            data_r_q   <= '0;
            s_addr_q   <= '0;
            s_rq_q     <= 1'b0;
            s_wr_q     <= 1'b0;
            s_data_w_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            data_r_q   <= data_r_d;
            s_addr_q   <= s_addr_d;
            s_rq_q     <= s_rq_d;
            s_wr_q     <= s_wr_d;
            s_data_w_q <= s_data_w_d;
        end
    end

    assign m_grant   = grant_q;
    assign m_ack     = ack_q;
    assign m_err     = err_q;
    assign m_dataR   = data_r_q;
    assign s_address = s_addr_q;
    assign s_rq      = s_rq_q;
    assign s_wr_ni   = s_wr_q;
    assign s_dataW   = s_data_w_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized transactions against a transaction-level arbiter model.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk;
    logic            reset;
    logic [N-1:0]    m_rq;
    logic [N*AW-1:0] m_address;
    logic [N-1:0]    m_wr_ni;
    logic [N*DW-1:0] m_dataW;
    logic [N-1:0]    m_grant;
    logic [N-1:0]    m_ack;
    logic            m_err;
    logic [DW-1:0]   m_dataR;
    logic [AW-1:0]   s_address;
    logic            s_rq;
    logic            s_wr_ni;
    logic [DW-1:0]   s_dataW;
    logic            s_ack;
    logic [DW-1:0]   s_dataR;

    int vectors;
    int miscompares;
    int mptr;
    logic [DW-1:0] mdata_r;
    logic [N-1:0]  grant_seen;

    bus_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_MASTERS(N), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_rq(m_rq), .m_address(m_address), .m_wr_ni(m_wr_ni), .m_dataW(m_dataW),
        .m_grant(m_grant), .m_ack(m_ack), .m_err(m_err), .m_dataR(m_dataR),
        .s_address(s_address), .s_rq(s_rq), .s_wr_ni(s_wr_ni), .s_dataW(s_dataW),
        .s_ack(s_ack), .s_dataR(s_dataR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] rq, input int p);
        for (int k = 0; k < N; k++) begin
            if (((rq >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_master(input int i, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] dw);
        m_rq              = m_rq | (N'(1) << i);
        m_wr_ni           = (m_wr_ni & ~(N'(1) << i)) | (N'(wr) << i);
        m_address[i*AW +: AW] = a;
        m_dataW[i*DW +: DW]   = dw;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, m_grant, 0);
        chk({tag, "_ack"}, m_ack, 0);
        chk({tag, "_err"}, m_err, 0);
        chk({tag, "_dataR"}, m_dataR, 0);
        chk({tag, "_s_rq"}, s_rq, 0);
        chk({tag, "_s_addr"}, s_address, 0);
        chk({tag, "_s_wr"}, s_wr_ni, 0);
        chk({tag, "_s_dataW"}, s_dataW, 0);
    endtask

    // One complete transaction; the slave acks on REQ cycle d (d >= TO means it never acks).
    task automatic txn(input int d, input logic [DW-1:0] rdata, input bit keep, input bit drop_mid);
        int win, n, hi;
        bit exp_err, unstable;
        logic [AW-1:0] ea;
        logic ew;
        logic [DW-1:0] ed;
        win = model_winner(m_rq, mptr);
        if (win < 0) win = 0;
        ea = m_address[win*AW +: AW];
        ew = ((m_wr_ni >> win) & 1) != 0;
        ed = m_dataW[win*DW +: DW];
        step();
        grant_seen = m_grant;
        chk("grant", m_grant, 32'(1) << win);
        chk("s_rq_rise", s_rq, 1);
        chk("s_addr", s_address, ea);
        chk("s_wr", s_wr_ni, ew);
        chk("s_dataW", s_dataW, ed);
        exp_err  = (d >= TO);
        n        = exp_err ? TO : d + 1;
        hi       = 1;
        unstable = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (drop_mid && c == 0) m_rq = m_rq & ~(N'(1) << win);
            s_ack   = (c == d);
            s_dataR = (c == d) ? rdata : DW'($urandom);
            step();
            s_ack = 1'b0;
            if (c < n - 1) begin
                if (s_rq === 1'b1) hi++;
                if (s_address !== ea || s_wr_ni !== ew || s_dataW !== ed || m_ack !== '0) unstable = 1'b1;
            end
        end
        if (!exp_err && ew) mdata_r = rdata;
        chk("rq_cycles", hi, n);
        chk("req_stable", unstable, 0);
        chk("ack", m_ack, 32'(1) << win);
        chk("err", m_err, exp_err);
        chk("dataR", m_dataR, mdata_r);
        chk("s_rq_fall", s_rq, 0);
        if (!keep) m_rq = m_rq & ~(N'(1) << win);
        step();
        chk("ack_clr", m_ack, 0);
        chk("err_clr", m_err, 0);
        chk("grant_clr", m_grant, 0);
        chk("s_rq_gap", s_rq, 0);
        mptr = (win + 1) % N;
    endtask

    initial begin
        int rr_order[5];
        vectors     = 0;
        miscompares = 0;
        mptr        = 0;
        mdata_r     = '0;
        rr_order    = '{0, 1, 2, 3, 0};
        m_rq = '0; m_address = '0; m_wr_ni = '0; m_dataW = '0;
        s_ack = 1'b0; s_dataR = '0;
        reset = 1'b0;
        step(); step(); step();
        check_all_zero("reset");
        reset = 1'b1;
        step();
        check_all_zero("post_reset");

        // single read from master 2
        set_master(2, 4'hA, 1'b1, 8'h00);
        txn(0, 8'h5C, 1'b0, 1'b0);
        chk("read_dataR", m_dataR, 8'h5C);

        // write from master 0 keeps m_dataR
        set_master(0, 4'h3, 1'b0, 8'h3E);
        txn(2, 8'hA7, 1'b0, 1'b0);
        chk("write_dataR_held", m_dataR, 8'h5C);

        // timeout, then a normal transaction
        set_master(1, 4'h7, 1'b1, 8'h11);
        txn(TO + 4, 8'h99, 1'b0, 1'b0);
        set_master(3, 4'h2, 1'b1, 8'h22);
        txn(1, 8'h6B, 1'b0, 1'b0);

        // all masters requesting continuously
        for (int i = 0; i < N; i++) set_master(i, AW'(i + 8), 1'b1, DW'(i));
        for (int k = 0; k < 5; k++) begin
            txn(k % 3, DW'(8'h40 + k), 1'b1, 1'b0);
            chk("rr_order", grant_seen, 32'(1) << rr_order[k]);
        end
        m_rq = '0;

        // s_ack outside REQ is ignored
        s_ack = 1'b1; s_dataR = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_ack", m_ack, 0);
            chk("idle_s_rq", s_rq, 0);
            chk("idle_dataR", m_dataR, mdata_r);
        end
        s_ack = 1'b0;

        // ack coincident with timeout expiry wins
        set_master(2, 4'h5, 1'b1, 8'h00);
        txn(TO - 1, 8'hC3, 1'b0, 1'b0);
        chk("ack_vs_timeout_err", m_err, 0);

        // master drops its request mid-transaction
        set_master(0, 4'h6, 1'b1, 8'h00);
        txn(3, 8'h81, 1'b0, 1'b1);

        // asynchronous reset during REQ
        set_master(1, 4'hC, 1'b0, 8'h55);
        step();
        chk("pre_reset_s_rq", s_rq, 1);
        m_rq = '0;
        #2 reset = 1'b0;
        #1;
        chk("async_s_rq", s_rq, 0);
        chk("async_grant", m_grant, 0);
        chk("async_ack", m_ack, 0);
        step();
        check_all_zero("mid_reset");
        reset   = 1'b1;
        mptr    = 0;
        mdata_r = '0;
        step();
        chk("after_reset_ack", m_ack, 0);
        set_master(3, 4'h1, 1'b1, 8'h00);
        set_master(0, 4'h9, 1'b1, 8'h00);
        txn(0, 8'h3C, 1'b0, 1'b0);
        chk("ptr_reset_winner", grant_seen, 4'b0001);
        txn(0, 8'h4D, 1'b0, 1'b0);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            int d;
            bit keep, drop;
            for (int i = 0; i < N; i++) begin
                if ((((m_rq >> i) & 1) == 0) && $urandom_range(0, 1) == 1)
                    set_master(i, AW'($urandom), 1'($urandom), DW'($urandom));
            end
            if (m_rq == '0) set_master(int'($urandom_range(0, N - 1)), AW'($urandom), 1'($urandom), DW'($urandom));
            d    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 2)) : int'($urandom_range(0, 4));
            keep = ($urandom_range(0, 3) == 0);
            drop = !keep && ($urandom_range(0, 7) == 0);
            txn(d, DW'($urandom), keep, drop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
